// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// riscv32_pkg
// Shared definitions for the RISC32 data-memory responder:
//   - state_e      : responder FSM states
//   - WORD_W/BYTE_W: data word and byte widths
//   - load_extend(): shapes raw memory words into load results
//                    (word pass-through, signed or unsigned byte)
// ---------------------------------------------------------------------------
package riscv32_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        MODIFY,
        RESP
    } state_e;

    // Byte loads use word bits [7:0]; sign- or zero-extend to a full word.
    function automatic logic [WORD_W-1:0] load_extend(
        input logic [WORD_W-1:0] word,
        input logic              is_byte,
        input logic              is_unsigned
    );
        if (!is_byte) begin
            return word;
        end
        if (is_unsigned) begin
            return {{(WORD_W-BYTE_W){1'b0}}, word[BYTE_W-1:0]};
        end
        return {{(WORD_W-BYTE_W){word[BYTE_W-1]}}, word[BYTE_W-1:0]};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Bundles the request channel, response channel and preload port of the
// data-memory responder.
//   master : the requester (core MEM stage, boot loader or bench)
//   slave  : the responder
// Request  : req_valid/req_ready, req_we, req_byte, req_unsigned,
//            req_addr, req_wdata
// Response : rsp_valid/rsp_ready, rsp_rdata, rsp_err
// Preload  : init_we, init_addr, init_data
// ---------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [31:0]       init_data;

    modport master (
        output req_valid, req_we, req_byte, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        output init_we, init_addr, init_data
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        input  init_we, init_addr, init_data
    );
endinterface

// File: rtl/dmem_responder_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port synchronous RAM, DEPTH x 32 bits, read-first, registered read
// (data for the address presented at an edge is visible after that edge).
// No reset on the storage or the read register so it maps onto block RAM.
// Ports:
//   clk1    : clock
//   i_we    : write enable
//   i_addr  : word address
//   i_wdata : write data
//   o_rdata : registered read data
// ---------------------------------------------------------------------------
module dmem_array
    import riscv32_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk1,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk1) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the RISC32 MEM stage. Serves one load/store at a
// time with LATENCY wait-state cycles, executes byte stores as read-modify-
// write, flags out-of-range addresses, and accepts preload writes in IDLE.
// Ports:
//   clk1 : system clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : dmem_responder_if.slave (request, response and preload channels)
// Timing (accept edge ends cycle N): load / word store response in cycle
// N+2+LATENCY, byte store one cycle later.
// ---------------------------------------------------------------------------
module dmem_responder
    import riscv32_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 1
) (
    input  logic             clk1,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
    localparam logic [3:0]  LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam int          N_LANES  = WORD_W / BYTE_W;

    // FSM
    state_e r_state;
    state_e w_state_next;

    // Latched request
    logic              r_we;
    logic              r_byte;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;

    // Datapath state
    logic [3:0]             r_wait_cnt;
    logic [WORD_W-1:0]      r_rdata;
    logic                   r_err;
    logic [WORD_W-1:BYTE_W] r_old_word;

    // Combinational
    logic              w_req_ready;
    logic              w_rsp_valid;
    logic              w_accept;
    logic              w_in_range;
    logic              w_init_hit;
    logic              w_ram_we;
    logic [AW-1:0]     w_ram_addr;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_ram_rdata;
    logic [WORD_W-1:0] w_merged;

    assign w_accept   = bus.req_valid && w_req_ready;
    assign w_in_range = (32'(r_addr) < DEPTH_U);
    assign w_init_hit = bus.init_we && (32'(bus.init_addr) < DEPTH_U);

    // Byte-store merge: lane 0 takes the new byte, upper lanes keep the old word.
    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            if (gi == 0) begin : g_new
                assign w_merged[BYTE_W-1:0] = r_wdata[BYTE_W-1:0];
            end else begin : g_old
                assign w_merged[gi*BYTE_W +: BYTE_W] = r_old_word[gi*BYTE_W +: BYTE_W];
            end
        end
    endgenerate

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (LATENCY > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (r_wait_cnt == LAT_LAST) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (w_in_range && r_we && r_byte) begin
                    w_state_next = MODIFY;
                end else begin
                    w_state_next = RESP;
                end
            end
            MODIFY: begin
                w_state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs and RAM port control ----------------
    // The RAM has a registered read, so the request address is presented one
    // cycle before ACCESS: in IDLE it follows req_addr (valid on the accept
    // edge when LATENCY=0), afterwards it holds the latched address, so the
    // word is already on w_ram_rdata during ACCESS.
    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_addr[AW-1:0];
        w_ram_wdata = r_wdata;
        case (r_state)
            IDLE: begin
                w_req_ready = !bus.init_we;
                if (bus.init_we) begin
                    w_ram_we    = w_init_hit;
                    w_ram_addr  = bus.init_addr[AW-1:0];
                    w_ram_wdata = bus.init_data;
                end else begin
                    w_ram_addr  = bus.req_addr[AW-1:0];
                end
            end
            ACCESS: begin
                w_ram_we = w_in_range && r_we && !r_byte;
            end
            MODIFY: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = w_merged;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
        // A reset cycle must never commit a pending store or preload.
        if (rst) begin
            w_req_ready = 1'b0;
            w_ram_we    = 1'b0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_byte     <= 1'b0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wait_cnt <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_old_word <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= bus.req_we;
                        r_byte     <= bus.req_byte;
                        r_unsigned <= bus.req_unsigned;
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        r_wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == LAT_LAST) begin
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ACCESS: begin
                    if (!w_in_range) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if (!r_we) begin
                        r_err   <= 1'b0;
                        r_rdata <= load_extend(w_ram_rdata, r_byte, r_unsigned);
                    end else begin
                        r_err      <= 1'b0;
                        r_rdata    <= '0;
                        r_old_word <= w_ram_rdata[WORD_W-1:BYTE_W];
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk1    (clk1),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench for dmem_responder (DEPTH=1024, ADDR_W=16, LATENCY=1).
// Each request pushes its expected {rdata, err, latency}; the response
// monitor pops and compares on every rsp handshake.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk1;
    logic rst;

    dmem_responder_if #(.ADDR_W(16)) bus ();

    dmem_responder #(
        .DEPTH   (1024),
        .ADDR_W  (16),
        .LATENCY (1)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   accept_cyc = 0;
    int   rsp_lat  = 0;
    logic prev_valid = 1'b0;

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end else begin
            n_pass++;
        end
    endtask

    // Response monitor: records first-valid latency and scores each handshake.
    always @(negedge clk1) begin : mon
        int   lat_now;
        exp_t e;
        lat_now = rsp_lat;
        if (bus.rsp_valid && !prev_valid) begin
            lat_now = cyc - accept_cyc;
        end
        rsp_lat    <= lat_now;
        prev_valid <= bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("rsp: rdata=0x%08h err=%0b lat=%0d (want 0x%08h %0b %0d)",
                         bus.rsp_rdata, bus.rsp_err, lat_now, e.rdata, e.err, e.lat);
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check("rsp_lat", 32'(lat_now), 32'(e.lat));
            end
        end
    end

    task automatic preload(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk1);
        bus.init_we   = 1'b1;
        bus.init_addr = addr;
        bus.init_data = data;
        @(negedge clk1);
        bus.init_we   = 1'b0;
        $display("preload: [%0d] = 0x%08h", addr, data);
    endtask

    task automatic do_req(input logic we, input logic byt, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          input logic push, input logic [31:0] er,
                          input logic ee, input int el);
        exp_t e;
        bit   ok;
        @(negedge clk1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_byte     = byt;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.lat   = el;
            sb_q.push_back(e);
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        if (!ok) check("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk1);
        #1;
        accept_cyc    = cyc;
        bus.req_valid = 1'b0;
        $display("req: we=%0b byte=%0b uns=%0b addr=%0d wdata=0x%08h", we, byt, uns, addr, wdata);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk1);
            if (sb_q.size() == 0 && !bus.rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            check("rsp_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    initial begin
        int c1;
        int c2;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_byte     = 1'b0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b1;
        bus.init_we      = 1'b0;
        bus.init_addr    = '0;
        bus.init_data    = '0;

        // Reset state
        repeat (2) @(negedge clk1);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // 1: word load, latency N+3
        preload(16'd200, 32'h0000_0009);
        do_req(1'b0, 1'b0, 1'b0, 16'd200, 32'h0, 1'b1, 32'h0000_0009, 1'b0, 2);
        wait_idle();

        // 2: signed / unsigned byte loads
        preload(16'd200, 32'h0000_00A5);
        do_req(1'b0, 1'b1, 1'b0, 16'd200, 32'h0, 1'b1, 32'hFFFF_FFA5, 1'b0, 2);
        wait_idle();
        do_req(1'b0, 1'b1, 1'b1, 16'd200, 32'h0, 1'b1, 32'h0000_00A5, 1'b0, 2);
        wait_idle();

        // 3: byte store (one cycle slower), word store, read back
        preload(16'd201, 32'h1234_5678);
        do_req(1'b1, 1'b1, 1'b0, 16'd201, 32'hFFFF_FFA5, 1'b1, 32'h0, 1'b0, 3);
        wait_idle();
        do_req(1'b1, 1'b0, 1'b0, 16'd202, 32'h0000_0011, 1'b1, 32'h0, 1'b0, 2);
        wait_idle();
        do_req(1'b0, 1'b0, 1'b0, 16'd201, 32'h0, 1'b1, 32'h1234_56A5, 1'b0, 2);
        wait_idle();

        // 4: response back-pressure
        @(posedge clk1);
        #1 bus.rsp_ready = 1'b0;
        do_req(1'b1, 1'b0, 1'b0, 16'd198, 32'h0005_8980, 1'b1, 32'h0, 1'b0, 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            if (bus.rsp_valid) break;
        end
        for (int i = 0; i < 3; i++) begin
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_rdata", bus.rsp_rdata, 32'd0);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk1);
        end
        @(posedge clk1);
        #1 bus.rsp_ready = 1'b1;
        wait_idle();
        do_req(1'b0, 1'b0, 1'b0, 16'd198, 32'h0, 1'b1, 32'h0005_8980, 1'b0, 2);
        wait_idle();

        // Back-to-back store then load, accepted the cycle after the response
        do_req(1'b1, 1'b0, 1'b0, 16'd210, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 2);
        c1 = accept_cyc;
        do_req(1'b0, 1'b0, 1'b0, 16'd210, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 2);
        c2 = accept_cyc;
        check("b2b_accept_gap", 32'(c2 - c1), 32'd4);
        wait_idle();

        // 5: out of range (1029 aliases word 5 if the range check were lost)
        preload(16'd5, 32'hDEAD_BEEF);
        do_req(1'b0, 1'b0, 1'b0, 16'd1029, 32'h0, 1'b1, 32'h0, 1'b1, 2);
        wait_idle();
        do_req(1'b1, 1'b0, 1'b0, 16'd1029, 32'h0000_0001, 1'b1, 32'h0, 1'b1, 2);
        wait_idle();
        preload(16'd1029, 32'h0000_0077);
        do_req(1'b0, 1'b0, 1'b0, 16'd5, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        wait_idle();

        // 6a: reset during MODIFY of a byte store drops it
        preload(16'd300, 32'h1234_5678);
        do_req(1'b1, 1'b1, 1'b0, 16'd300, 32'h0000_00A5, 1'b0, 32'h0, 1'b0, 0);
        @(posedge clk1);
        @(posedge clk1);
        #1 rst = 1'b1;
        @(negedge clk1);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk1);
        #1 rst = 1'b0;
        @(negedge clk1);
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        do_req(1'b0, 1'b0, 1'b0, 16'd300, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 2);
        wait_idle();

        // 6b: preload wins over a same-cycle request
        @(negedge clk1);
        bus.init_we      = 1'b1;
        bus.init_addr    = 16'd400;
        bus.init_data    = 32'h0BAD_F00D;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_byte     = 1'b0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 16'd400;
        sb_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, lat: 2});
        #1;
        check("init_prio_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk1);
        #1 bus.init_we = 1'b0;
        @(negedge clk1);
        check("after_init_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk1);
        #1;
        accept_cyc    = cyc;
        bus.req_valid = 1'b0;
        $display("req: load addr=400 after preload collision");
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined RISC32 core. It serves load/store requests issued by the core's MEM stage over a valid/ready request channel and a valid/ready response channel. Memory is word-addressed, 32-bit words, with programmable wait states. A byte-store is executed as an internal read-modify-write. A preload port lets benches and the boot loader fill memory without hierarchical pokes.

Parameters:
DEPTH, 1024, number of 32-bit words
ADDR_W, 16, request address width; addresses >= DEPTH are out of range
LATENCY, 1, wait-state cycles inserted before each access (0..15)

Ports:
clk1  in  1  single system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_byte  in  1  1 = byte op on word bits [7:0], 0 = full word
req_unsigned  in  1  byte load only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  word address
req_wdata  in  32  store data; byte store uses [7:0]
rsp_valid  out  1  response present
rsp_ready  in  1  core accepts the response
rsp_rdata  out  32  load data; 0 for stores and errors
rsp_err  out  1  address out of range
init_we  in  1  preload write strobe
init_addr  in  ADDR_W  preload word address
init_data  in  32  preload data

Behaviour:
- Reset values: req_ready=0 during reset, then 1 in IDLE; rsp_valid=0; rsp_rdata=0; rsp_err=0; FSM=IDLE; wait counter=0. The memory array is not cleared.
- Only one request is outstanding at a time. req_ready = (state==IDLE) && !init_we.
- Accept = req_valid && req_ready. On accept, latch we, byte, unsigned, addr and wdata.
- States:
  - IDLE: on accept, go to WAIT if LATENCY>0, else ACCESS.
  - WAIT: count LATENCY cycles, then go to ACCESS.
  - ACCESS:
    - Out of range: set rsp_err=1, rdata=0, no write, go to RESP.
    - Load: read the word. For a word load, rdata=word. For a byte load, rdata is {24{word[7]}, word[7:0]} when signed, or {24'b0, word[7:0]} when unsigned. Go to RESP.
    - Word store: write the word, go to RESP.
    - Byte store: read the word, go to MODIFY.
  - MODIFY: write {old[31:8], wdata[7:0]}, go to RESP.
  - RESP: assert rsp_valid and hold rsp_rdata/rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and clear rsp_* on the same edge.
- Latency (accept edge = cycle N):
  - Load or word store: rsp_valid first high in cycle N+1+LATENCY+1.
  - Byte store: one cycle later.
  - With rsp_ready held at 1, the next request can be accepted in the cycle after the response cycle.
- Preload: init_we writes are honoured only in IDLE and take priority over a request in the same cycle; that request is not accepted. Outside IDLE, init_we is ignored. Out-of-range preload addresses are dropped.
- Reset mid-operation: return to IDLE and drop the response. A store not yet written leaves memory unchanged. A byte store reset between ACCESS and MODIFY leaves the word intact.
- A back-to-back store followed by a load to the same address returns the stored value; no forwarding is needed because accesses are serialized.

Decomposition:
- Shared package (riscv32_pkg): state enum {IDLE, WAIT, ACCESS, MODIFY, RESP}; constants WORD_W=32, BYTE_W=8.
- Sub-module dmem_array: single-port synchronous RAM with DEPTH x 32, ports we/addr/wdata/rdata, and a 1-cycle read. The FSM owns arbitration between preload and requests.

Test Plan:
1. Preload [200]=0x00000009; load word at 200 with LATENCY=1 -> rsp_valid in cycle N+3, rdata=0x00000009, err=0.
2. Preload [200]=0x000000A5; signed byte load -> 0xFFFFFFA5; unsigned byte load -> 0x000000A5.
3. Preload [201]=0x12345678; byte store wdata=0xFFFFFFA5 to 201; then load word at 201 -> 0x123456A5. The byte-store response arrives one cycle later than a word store.
4. Store word 0x00058980 to 198; hold rsp_ready=0 for 3 cycles -> rsp_valid stays high with stable data and req_ready stays 0; then load 198 -> 0x00058980.
5. Load from DEPTH+5 -> rsp_err=1, rdata=0; a store to DEPTH+5 leaves memory unchanged.
6. Assert rst during MODIFY of a byte store to a word holding 0x12345678 -> word still reads 0x12345678 and rsp_valid=0. Also check that init_we asserted with req_valid in IDLE gives preload priority and req_ready=0.
